spi_mem_arbiter: RTL and testbench

- Shares the single off-chip SPI bus (flash for program/ROM data, SPI SRAM for data RAM) between NREQ byte-wide requesters: CU instruction/operand fetch, RAM data port and debug loader.
- Arbitrates round-robin, then runs one complete SPI mode-0 transaction per grant: CMD, 24-bit address, one data byte.
- Returns a one-cycle done pulse to the winner. Replaces per-client spi_executing/spi_done wiring with one request/done handshake per client.

---
 rtl/spi_mem_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 29 ++
 rtl/spi_mem_arbiter.sv | 158 +++++++++++++++
 tb/tb_spi_mem_arbiter.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_mem_pkg.sv
// Shared types and constants for the SPI memory bus arbiter.
package spi_mem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    DONE,
    GAP
  } state_t;

  localparam logic [7:0]  CMD_READ   = 8'h03;
  localparam logic [7:0]  CMD_WRITE  = 8'h02;
  localparam logic        TGT_FLASH  = 1'b0;
  localparam logic        TGT_RAM    = 1'b1;
  localparam int unsigned SHIFT_BITS = 40;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request after ptr, with wrap.
module rr_arbiter #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx,
  output logic            valid
);

  always_comb begin
    logic [IW-1:0] cand;
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    cand  = '0;
    for (int unsigned off = 1; off <= NREQ; off++) begin
      cand = IW'((32'(ptr) + off) % NREQ);
      if (!valid && req[cand]) begin
        valid     = 1'b1;
        idx       = cand;
        gnt[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_mem_arbiter.sv
// Round-robin arbiter sharing one SPI mode-0 bus (flash + SPI SRAM) between
// byte-wide requesters; one CMD/addr24/data frame per grant.
module spi_mem_arbiter
  import spi_mem_pkg::*;
#(
  parameter int unsigned NREQ   = 3,
  parameter int unsigned ADDR_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ-1:0]        we,
  input  logic [NREQ-1:0]        tgt,
  input  logic [NREQ*ADDR_W-1:0] addr,
  input  logic [NREQ*8-1:0]      wdata,
  output logic [NREQ-1:0]        gnt,
  output logic [NREQ-1:0]        done,
  output logic [7:0]             rdata,
  output logic                   busy,
  output logic                   spi_sclk,
  output logic                   spi_mosi,
  input  logic                   spi_miso,
  output logic                   spi_cs_flash_n,
  output logic                   spi_cs_ram_n
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t                  state;
  logic [IW-1:0]           ptr;
  logic [NREQ-1:0]         arb_gnt;
  logic [IW-1:0]           arb_idx;
  logic                    arb_valid;

  logic                    sel_we, sel_tgt, skip;
  logic [ADDR_W-1:0]       sel_addr;
  logic [7:0]              sel_wdata;
  logic [23:0]             addr24;
  logic [SHIFT_BITS-1:0]   frame;

  logic [SHIFT_BITS-2:0]   shreg;
  logic [5:0]              bit_cnt;
  logic                    phase;
  logic [6:0]              rx;
  logic                    lat_we, lat_skip;

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
    .req  (req),
    .ptr  (ptr),
    .gnt  (arb_gnt),
    .idx  (arb_idx),
    .valid(arb_valid)
  );

  // Mux the winner's fields with the one-hot grant and build its frame.
  always_comb begin
    sel_we    = 1'b0;
    sel_tgt   = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (arb_gnt[i]) begin
        sel_we    = sel_we | we[i];
        sel_tgt   = sel_tgt | tgt[i];
        sel_addr  = sel_addr | ADDR_W'(addr >> (i * ADDR_W));
        sel_wdata = sel_wdata | 8'(wdata >> (i * 8));
      end
    end
    addr24               = '0;
    addr24[ADDR_W-1:0]   = sel_addr;
    skip                 = sel_we && (sel_tgt == TGT_FLASH);
    frame = {sel_we ? CMD_WRITE : CMD_READ, addr24, sel_we ? sel_wdata : 8'h00};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      ptr            <= IW'(NREQ - 1);
      gnt            <= '0;
      done           <= '0;
      rdata          <= '0;
      busy           <= 1'b0;
      spi_sclk       <= 1'b0;
      spi_mosi       <= 1'b0;
      spi_cs_flash_n <= 1'b1;
      spi_cs_ram_n   <= 1'b1;
      shreg          <= '0;
      bit_cnt        <= '0;
      phase          <= 1'b0;
      rx             <= '0;
      lat_we         <= 1'b0;
      lat_skip       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_valid) begin
            state    <= SETUP;
            ptr      <= arb_idx;
            gnt      <= arb_gnt;
            busy     <= 1'b1;
            lat_we   <= sel_we;
            lat_skip <= skip;
            shreg    <= frame[SHIFT_BITS-2:0];
            // Outputs are registered, so SETUP's CS and first bit are set here.
            if (!skip) begin
              spi_mosi <= frame[SHIFT_BITS-1];
              if (sel_tgt == TGT_RAM) spi_cs_ram_n   <= 1'b0;
              else                    spi_cs_flash_n <= 1'b0;
            end
          end
        end
        SETUP: begin
          bit_cnt <= '0;
          phase   <= 1'b0;
          if (lat_skip) begin
            state <= DONE;
            done  <= gnt;
          end else begin
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (!phase) begin
            spi_sclk <= 1'b1;
            phase    <= 1'b1;
          end else begin
            spi_sclk <= 1'b0;
            phase    <= 1'b0;
            rx       <= {rx[5:0], spi_miso};
            shreg    <= {shreg[SHIFT_BITS-3:0], 1'b0};
            if (bit_cnt == 6'(SHIFT_BITS - 1)) begin
              state          <= DONE;
              done           <= gnt;
              spi_mosi       <= 1'b0;
              spi_cs_flash_n <= 1'b1;
              spi_cs_ram_n   <= 1'b1;
              if (!lat_we) rdata <= {rx, spi_miso};
            end else begin
              spi_mosi <= shreg[SHIFT_BITS-2];
              bit_cnt  <= bit_cnt + 6'd1;
            end
          end
        end
        DONE: begin
          done  <= '0;
          gnt   <= '0;
          state <= GAP;
        end
        GAP: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_mem_arbiter.sv
// Self-checking bench for spi_mem_arbiter with an SPI slave model on miso.
module tb_spi_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req, we, tgt;
  logic [15:0] a_arr [3];
  logic [7:0]  d_arr [3];
  logic [47:0] addr;
  logic [23:0] wdata;
  logic [2:0]  gnt, done;
  logic [7:0]  rdata;
  logic        busy, spi_sclk, spi_mosi, spi_miso, spi_cs_flash_n, spi_cs_ram_n;

  int checks = 0;
  int failures = 0;
  int m_ptr = 2;
  logic [7:0] rd_model = 8'h00;

  assign addr  = {a_arr[2], a_arr[1], a_arr[0]};
  assign wdata = {d_arr[2], d_arr[1], d_arr[0]};

  always #5 clk = ~clk;

  spi_mem_arbiter #(.NREQ(3), .ADDR_W(16)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .tgt(tgt), .addr(addr), .wdata(wdata),
    .gnt(gnt), .done(done), .rdata(rdata), .busy(busy),
    .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
    .spi_cs_flash_n(spi_cs_flash_n), .spi_cs_ram_n(spi_cs_ram_n)
  );

  // Slave model: captures mosi on sclk rise; returns miso_byte in bits 32..39.
  logic [7:0]  miso_byte = 8'h00;
  logic [39:0] cap = '0;
  int          nrise = 0;
  int          sclk_total = 0;
  logic        cs_idle;
  assign cs_idle = spi_cs_flash_n & spi_cs_ram_n;

  always @(posedge spi_sclk or negedge cs_idle) begin
    if (spi_sclk) begin
      cap   <= {cap[38:0], spi_mosi};
      nrise <= nrise + 1;
    end else begin
      cap   <= '0;
      nrise <= 0;
    end
  end

  always @(posedge spi_sclk) sclk_total <= sclk_total + 1;

  function automatic logic miso_bit(input int nr, input logic [7:0] mb);
    int b;
    b = nr - 1;
    if (b >= 32 && b <= 39) return mb[39-b];
    return b[0];
  endfunction

  assign spi_miso = miso_bit(nrise, miso_byte);

  // Bus-rule monitor: never both CS low; CS only changes with sclk low.
  int   viol = 0;
  logic pcf = 1'b1, pcr = 1'b1, prst = 1'b1;
  always @(negedge clk) begin
    if (spi_cs_flash_n === 1'b0 && spi_cs_ram_n === 1'b0) viol++;
    if (!rst && !prst && ({spi_cs_flash_n, spi_cs_ram_n} !== {pcf, pcr}) && spi_sclk) viol++;
    pcf  = spi_cs_flash_n;
    pcr  = spi_cs_ram_n;
    prst = rst;
  end

  function automatic int exp_winner(input logic [2:0] m, input int p);
    for (int off = 1; off <= 3; off++) if (m[(p + off) % 3]) return (p + off) % 3;
    return -1;
  endfunction

  function automatic logic [39:0] exp_frame(input logic w, input logic [15:0] a, input logic [7:0] d);
    return {w ? 8'h02 : 8'h03, 8'h00, a, w ? d : 8'h00};
  endfunction

  // Drives req=mask from IDLE, measures until done, then drops req and waits for IDLE.
  task automatic do_txn(input logic [2:0] mask, output int lat, output int fl_low, output int rm_low,
                        output int gbad, output int rises, output logic [2:0] dvec,
                        output logic [2:0] gseen, output logic [2:0] dafter);
    int s0;
    s0 = sclk_total; lat = -1; fl_low = 0; rm_low = 0; gbad = 0; dvec = '0; gseen = '0;
    req = mask;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (!spi_cs_flash_n) fl_low++;
      if (!spi_cs_ram_n) rm_low++;
      if (!$onehot0(gnt)) gbad++;
      gseen = gseen | gnt;
      if (done !== 3'b000) begin
        lat = n; dvec = done;
        break;
      end
    end
    req = '0;
    @(negedge clk);
    dafter = done;
    repeat (2) @(negedge clk);
    rises = sclk_total - s0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (busy === 1'b0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; req = '0; we = '0; tgt = '0;
    for (int i = 0; i < 3; i++) begin a_arr[i] = '0; d_arr[i] = '0; end
    repeat (2) @(negedge clk);
    checks++; if (gnt !== 3'b000) begin failures++; $display("FAIL reset_gnt: got %b expected 000", gnt); end
    checks++; if (done !== 3'b000) begin failures++; $display("FAIL reset_done: got %b expected 000", done); end
    checks++; if (rdata !== 8'h00) begin failures++; $display("FAIL reset_rdata: got %h expected 00", rdata); end
    checks++; if ({busy, spi_sclk, spi_mosi} !== 3'b000) begin failures++; $display("FAIL reset_busy_sclk_mosi: got %b expected 000", {busy, spi_sclk, spi_mosi}); end
    checks++; if ({spi_cs_flash_n, spi_cs_ram_n} !== 2'b11) begin failures++; $display("FAIL reset_cs: got %b expected 11", {spi_cs_flash_n, spi_cs_ram_n}); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    m_ptr = 2; rd_model = 8'h00;
  endtask

  task automatic test_single_read;
    int lat, fl, rm, gb, rs; logic [2:0] dv, gs, da;
    we[0] = 1'b0; tgt[0] = 1'b0; a_arr[0] = 16'h1234; d_arr[0] = 8'h77; miso_byte = 8'hA5;
    do_txn(3'b001, lat, fl, rm, gb, rs, dv, gs, da);
    checks++; if (lat !== 82) begin failures++; $display("FAIL read_latency: got %0d expected 82", lat); end
    checks++; if (dv !== 3'b001) begin failures++; $display("FAIL read_done: got %b expected 001", dv); end
    checks++; if (da !== 3'b000) begin failures++; $display("FAIL read_done_width: got %b expected 000", da); end
    checks++; if (fl !== 81 || rm !== 0) begin failures++; $display("FAIL read_cs: got flash_low=%0d ram_low=%0d expected 81/0", fl, rm); end
    checks++; if (cap !== 40'h03_00_12_34_00) begin failures++; $display("FAIL read_mosi: got %h expected 0300123400", cap); end
    checks++; if (rdata !== 8'hA5) begin failures++; $display("FAIL read_rdata: got %h expected a5", rdata); end
    checks++; if (gs !== 3'b001 || gb !== 0) begin failures++; $display("FAIL read_gnt: got %b bad=%0d expected 001", gs, gb); end
    m_ptr = 0; rd_model = 8'hA5;
  endtask

  task automatic test_sram_write;
    int lat, fl, rm, gb, rs; logic [2:0] dv, gs, da;
    we[1] = 1'b1; tgt[1] = 1'b1; a_arr[1] = 16'h00FF; d_arr[1] = 8'h5C; miso_byte = 8'h3C;
    do_txn(3'b010, lat, fl, rm, gb, rs, dv, gs, da);
    checks++; if (lat !== 82 || dv !== 3'b010) begin failures++; $display("FAIL wr_done: got lat=%0d done=%b expected 82/010", lat, dv); end
    checks++; if (fl !== 0 || rm !== 81) begin failures++; $display("FAIL wr_cs: got flash_low=%0d ram_low=%0d expected 0/81", fl, rm); end
    checks++; if (cap !== 40'h02_00_00_FF_5C) begin failures++; $display("FAIL wr_mosi: got %h expected 020000ff5c", cap); end
    checks++; if (rdata !== rd_model) begin failures++; $display("FAIL wr_rdata_held: got %h expected %h", rdata, rd_model); end
    m_ptr = 1;
  endtask

  task automatic test_flash_write;
    int lat, fl, rm, gb, rs; logic [2:0] dv, gs, da;
    we[2] = 1'b1; tgt[2] = 1'b0; a_arr[2] = 16'h4321; d_arr[2] = 8'h99; miso_byte = 8'hFF;
    do_txn(3'b100, lat, fl, rm, gb, rs, dv, gs, da);
    checks++; if (lat !== 2 || dv !== 3'b100) begin failures++; $display("FAIL fwr_done: got lat=%0d done=%b expected 2/100", lat, dv); end
    checks++; if (rs !== 0) begin failures++; $display("FAIL fwr_sclk: got %0d rises expected 0", rs); end
    checks++; if (fl !== 0 || rm !== 0) begin failures++; $display("FAIL fwr_cs: got flash_low=%0d ram_low=%0d expected 0/0", fl, rm); end
    checks++; if (rdata !== rd_model) begin failures++; $display("FAIL fwr_rdata_held: got %h expected %h", rdata, rd_model); end
    m_ptr = 2;
  endtask

  task automatic test_contention;
    int order [4]; int t_start [4]; int ng, bad, p, e; logic gap_seen; logic [2:0] pg; bit ok;
    ng = 0; bad = 0; gap_seen = 1'b1; pg = '0;
    for (int k = 0; k < 4; k++) begin order[k] = -1; t_start[k] = 0; end
    rst = 1'b1; repeat (2) @(negedge clk); rst = 1'b0; @(negedge clk);
    m_ptr = 2; rd_model = 8'h00;
    for (int i = 0; i < 3; i++) begin we[i] = 1'b0; tgt[i] = 1'b1; a_arr[i] = 16'($urandom); end
    req = 3'b111;
    for (int cyc = 0; cyc < 500 && ng < 4; cyc++) begin
      @(negedge clk);
      if (!$onehot0(gnt)) bad++;
      if (gnt === 3'b000 && cs_idle === 1'b1) gap_seen = 1'b1;
      if (gnt !== 3'b000 && gnt !== pg) begin
        if (!gap_seen || pg !== 3'b000) bad++;
        order[ng] = $clog2(gnt); t_start[ng] = cyc; ng++; gap_seen = 1'b0;
      end
      pg = gnt;
    end
    req = '0;
    wait_idle(ok);
    checks++; if (!ok || ng !== 4) begin failures++; $display("FAIL cont_grants: got %0d grants idle=%0d expected 4/1", ng, ok); end
    p = m_ptr;
    for (int k = 0; k < 4; k++) begin
      e = exp_winner(3'b111, p);
      checks++; if (order[k] !== e) begin failures++; $display("FAIL cont_order%0d: got %0d expected %0d", k, order[k], e); end
      p = e;
    end
    for (int k = 1; k < 4; k++) begin
      checks++; if (t_start[k] - t_start[k-1] < 84) begin failures++; $display("FAIL cont_spacing%0d: got %0d expected >=84", k, t_start[k] - t_start[k-1]); end
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL cont_overlap_gap: got %0d bad cycles expected 0", bad); end
    m_ptr = p;
    rd_model = miso_byte;
  endtask

  task automatic test_reset_mid_shift;
    bit ok; bit hit; logic [2:0] first;
    we[0] = 1'b0; tgt[0] = 1'b1; a_arr[0] = 16'hBEEF; miso_byte = 8'h6E;
    req = 3'b001; hit = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (nrise == 18) begin hit = 1'b1; break; end
    end
    checks++; if (!hit) begin failures++; $display("FAIL rst_mid_reach: got no bit 17 expected reached"); end
    rst = 1'b1;
    #1;
    checks++; if ({spi_cs_flash_n, spi_cs_ram_n, spi_sclk} !== 3'b110) begin failures++; $display("FAIL rst_mid_bus: got cs/sclk=%b expected 110", {spi_cs_flash_n, spi_cs_ram_n, spi_sclk}); end
    checks++; if (gnt !== 3'b000 || busy !== 1'b0) begin failures++; $display("FAIL rst_mid_gnt_busy: got gnt=%b busy=%b expected 000/0", gnt, busy); end
    for (int i = 0; i < 3; i++) begin we[i] = 1'b0; tgt[i] = 1'b1; end
    req = 3'b111;
    repeat (2) @(negedge clk);
    rst = 1'b0; m_ptr = 2; first = '0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (gnt !== 3'b000) begin first = gnt; break; end
    end
    req = '0;
    checks++; if (first !== 3'b001) begin failures++; $display("FAIL rst_mid_first_gnt: got %b expected 001", first); end
    wait_idle(ok);
    repeat (2) @(negedge clk);
    rd_model = miso_byte; m_ptr = 0;
    checks++; if (!ok || rdata !== rd_model) begin failures++; $display("FAIL rst_mid_after: got rdata=%h idle=%0d expected %h/1", rdata, ok, rd_model); end
  endtask

  task automatic test_req_drop;
    int pulses, regrants; bit hit; logic [2:0] pg;
    we[1] = 1'b0; tgt[1] = 1'b0; a_arr[1] = 16'($urandom); miso_byte = 8'($urandom);
    req = 3'b010; hit = 1'b0; pulses = 0; regrants = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (nrise == 6) begin hit = 1'b1; break; end
    end
    req = '0; pg = gnt;
    checks++; if (!hit) begin failures++; $display("FAIL drop_reach: got no bit 5 expected reached"); end
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (done[1] === 1'b1) pulses++;
      if (gnt[1] === 1'b1 && pg[1] === 1'b0) regrants++;
      pg = gnt;
    end
    checks++; if (pulses !== 1) begin failures++; $display("FAIL drop_done: got %0d pulses expected 1", pulses); end
    checks++; if (regrants !== 0) begin failures++; $display("FAIL drop_regrant: got %0d expected 0", regrants); end
    rd_model = miso_byte; m_ptr = 1;
    checks++; if (rdata !== rd_model) begin failures++; $display("FAIL drop_rdata: got %h expected %h", rdata, rd_model); end
  endtask

  task automatic test_random;
    int lat, fl, rm, gb, rs, w, elat; logic [2:0] dv, gs, da, mask; logic legal;
    for (int it = 0; it < 16; it++) begin
      mask = 3'($urandom_range(1, 7));
      for (int i = 0; i < 3; i++) begin
        we[i] = 1'($urandom); tgt[i] = 1'($urandom); a_arr[i] = 16'($urandom); d_arr[i] = 8'($urandom);
      end
      miso_byte = 8'($urandom);
      w = exp_winner(mask, m_ptr);
      legal = !(we[w] && tgt[w] == 1'b0);
      elat = legal ? 82 : 2;
      do_txn(mask, lat, fl, rm, gb, rs, dv, gs, da);
      if (legal && !we[w]) rd_model = miso_byte;
      checks++; if (dv !== 3'(1 << w) || lat !== elat) begin failures++; $display("FAIL rand%0d_done: got done=%b lat=%0d expected %b/%0d", it, dv, lat, 3'(1 << w), elat); end
      checks++; if (legal && cap !== exp_frame(we[w], a_arr[w], d_arr[w])) begin failures++; $display("FAIL rand%0d_mosi: got %h expected %h", it, cap, exp_frame(we[w], a_arr[w], d_arr[w])); end
      checks++; if (fl !== ((legal && !tgt[w]) ? 81 : 0) || rm !== ((legal && tgt[w]) ? 81 : 0)) begin failures++; $display("FAIL rand%0d_cs: got flash_low=%0d ram_low=%0d tgt=%0d legal=%0d", it, fl, rm, tgt[w], legal); end
      checks++; if (rdata !== rd_model) begin failures++; $display("FAIL rand%0d_rdata: got %h expected %h", it, rdata, rd_model); end
      m_ptr = w;
    end
  endtask

  task automatic test_bus_rules;
    checks++; if (viol !== 0) begin failures++; $display("FAIL bus_rules: got %0d violations expected 0", viol); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_sram_write();
    test_flash_write();
    test_contention();
    test_reset_mid_shift();
    test_req_drop();
    test_random();
    test_bus_rules();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
